pgr_uart_tx_32bit: RTL and testbench



---
 rtl/pgr_uart_pkg.sv | 42 ++++
 rtl/pgr_uart_baud_tick_cnt.sv | 30 +++
 rtl/pgr_uart_tx_32bit.sv | 151 +++++++++++++++
 tb/tb_pgr_uart_tx_32bit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pgr_uart_pkg.sv
// Shared UART definitions: FSM state encoding, word-length codes, parity constants
// and frame-bit helpers. Intended for both the transmitter and the receiver.
package pgr_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] WL_5 = 2'b00;
  localparam logic [1:0] WL_6 = 2'b01;
  localparam logic [1:0] WL_7 = 2'b10;
  localparam logic [1:0] WL_8 = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Index of the last data bit: N-1 = word_len + 4.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wl);
    return 3'(wl) + 3'd4;
  endfunction

  // Serial position idx maps to data bit idx (LSB first) or N-1-idx (MSB first).
  function automatic logic frame_bit(input logic [7:0] d, input logic [2:0] idx,
                                     input logic [1:0] wl, input logic msb_first);
    logic [2:0] pos;
    pos = msb_first ? (last_bit_idx(wl) - idx) : idx;
    return d[pos];
  endfunction

  // Parity covers only the N transmitted bits; XOR of data and parity equals ptype.
  function automatic logic frame_parity(input logic [7:0] d, input logic [1:0] wl,
                                        input logic ptype);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - wl);
    return (^(d & mask)) ^ ptype;
  endfunction

endpackage

// File: rtl/pgr_uart_baud_tick_cnt.sv
// Per-bit divider: counts clk_en ticks 0..BIT_TICKS-1 and flags the last tick of a bit.
// clr_i holds the count at zero while the transmitter is idle.
module pgr_uart_baud_tick_cnt #(
  parameter int BIT_TICKS = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic adv_o
);
  localparam logic [3:0] LAST = 4'(BIT_TICKS - 1);

  logic [3:0] cnt_q, cnt_d;

  assign adv_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (adv_o) cnt_d = '0;
    else if (en_i)  cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pgr_uart_tx_32bit.sv
// UART transmitter: pops bytes from an FWFT FIFO and sends start/data/parity/stop frames.
// Optional macro UART_TX_TWO_STOP_EN selects two stop bits instead of one.
module pgr_uart_tx_32bit
  import pgr_uart_pkg::*;
#(
  parameter int BIT_TICKS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [7:0] tx_fifo_rd_data,
  input  logic       tx_fifo_rd_data_valid,
  output logic       tx_fifo_rd_data_req,
  input  logic [1:0] uart_word_len,
  input  logic       uart_parity_en,
  input  logic       uart_parity_type,
  input  logic       uart_mode,
  output logic       tx_busy,
  output logic       txd_out,
  output logic [2:0] dbg_state_o
);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic [7:0] data_q;
  logic [1:0] wl_q;
  logic       par_en_q, par_type_q, mode_q;
  logic       load, tick_adv, tick_clr;

  assign tick_clr = (state_q == ST_IDLE);

  pgr_uart_baud_tick_cnt #(.BIT_TICKS(BIT_TICKS)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (tick_clr),
    .en_i   (clk_en),
    .adv_o  (tick_adv)
  );

  // FIFO handshake: the head word is consumed on a clk where req=1; req is only
  // raised in IDLE on a clk_en tick while valid=1, and is held low during reset.
  assign tx_fifo_rd_data_req = load & rst_n;
  assign txd_out             = txd_q;
  assign tx_busy             = busy_q;
  assign dbg_state_o         = state_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clk_en && tx_fifo_rd_data_valid) begin
          load    = 1'b1;
          state_d = ST_START;
          bit_d   = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tick_adv) begin
          state_d = ST_DATA;
          bit_d   = '0;
          txd_d   = frame_bit(data_q, 3'd0, wl_q, mode_q);
        end
      end
      ST_DATA: begin
        if (tick_adv) begin
          if (bit_q == last_bit_idx(wl_q)) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              txd_d   = frame_parity(data_q, wl_q, par_type_q);
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = frame_bit(data_q, bit_q + 3'd1, wl_q, mode_q);
          end
        end
      end
      ST_PARITY: begin
        if (tick_adv) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick_adv) begin
`ifdef UART_TX_TWO_STOP_EN
          if (bit_q == 3'd0) begin
            bit_d = 3'd1;
          end else begin
            state_d = ST_IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
          end
`else
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // Frame format is frozen at pop time so config writes only affect later frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      wl_q       <= WL_8;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      mode_q     <= 1'b0;
    end else if (load) begin
      data_q     <= tx_fifo_rd_data;
      wl_q       <= uart_word_len;
      par_en_q   <= uart_parity_en;
      par_type_q <= uart_parity_type;
      mode_q     <= uart_mode;
    end
  end

endmodule

// File: tb/tb_pgr_uart_tx_32bit.sv
// Bench for pgr_uart_tx_32bit: FIFO model, per-tick line scoreboard and a frame-level
// reference model built from the frame rules (start, N data, parity, stop).
module tb_pgr_uart_tx_32bit;
  localparam int BIT_TICKS = 6;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       clk_en = 1'b0;
  logic [7:0] tx_fifo_rd_data = 8'h00;
  logic       tx_fifo_rd_data_valid = 1'b0;
  logic       tx_fifo_rd_data_req;
  logic [1:0] uart_word_len = 2'b11;
  logic       uart_parity_en = 1'b0;
  logic       uart_parity_type = 1'b0;
  logic       uart_mode = 1'b0;
  logic       tx_busy;
  logic       txd_out;
  logic [2:0] dbg_state;

  pgr_uart_tx_32bit #(.BIT_TICKS(BIT_TICKS)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .clk_en                (clk_en),
    .tx_fifo_rd_data       (tx_fifo_rd_data),
    .tx_fifo_rd_data_valid (tx_fifo_rd_data_valid),
    .tx_fifo_rd_data_req   (tx_fifo_rd_data_req),
    .uart_word_len         (uart_word_len),
    .uart_parity_en        (uart_parity_en),
    .uart_parity_type      (uart_parity_type),
    .uart_mode             (uart_mode),
    .tx_busy               (tx_busy),
    .txd_out               (txd_out),
    .dbg_state_o           (dbg_state)
  );

  // ---------------- bench state ----------------
  logic [7:0] fifo_q[$];
  logic [0:0] exp_q[$];
  int         req_ticks[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         tick_no = 0;
  bit         pop_pend = 1'b0;
  int         en_div = 1;
  bit         en_rand = 1'b0;
  int         en_phase = 0;
  logic [0:0] e_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (tick %0d)", name, tick_no);
  endtask

  // Reference model: expected line level for every clk_en tick of one frame.
  task automatic push_frame(input logic [7:0] d, input logic [1:0] wl, input logic pen,
                            input logic ptype, input logic msbf);
    int n;
    int ones;
    logic [0:0] lvl[$];
    n = int'(wl) + 5;
    ones = 0;
    lvl.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      int k;
      k = msbf ? (n - 1 - i) : i;
      lvl.push_back(d[k]);
      if (d[k]) ones++;
    end
    if (pen) lvl.push_back(1'((ones % 2) == 1) ^ ptype);
    for (int s = 0; s < STOP_BITS; s++) lvl.push_back(1'b1);
    foreach (lvl[j]) for (int t = 0; t < BIT_TICKS; t++) exp_q.push_back(lvl[j]);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pend) begin
      void'(fifo_q.pop_front());
      pop_pend = 1'b0;
    end
    if (en_div <= 1) clk_en = 1'b1;
    else if (en_rand) clk_en = ($urandom_range(0, en_div - 1) == 0);
    else begin
      en_phase = (en_phase + 1) % en_div;
      clk_en = (en_phase == 0);
    end
    tx_fifo_rd_data_valid = (fifo_q.size() > 0);
    tx_fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
  endtask

  task automatic run_until_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = (fifo_q.size() == 0) && !pop_pend && !tx_busy && (exp_q.size() == 0);
    end
    if (!done) fail_now("timeout waiting for transmitter idle");
  endtask

  task automatic set_cfg(input logic [1:0] wl, input logic pen, input logic ptype, input logic msbf);
    uart_word_len = wl;
    uart_parity_en = pen;
    uart_parity_type = ptype;
    uart_mode = msbf;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pop_pend = 1'b0;
    end else begin
      if (clk_en) begin
        tick_no++;
        if (tx_busy) begin
          if (exp_q.size() == 0) fail_now("busy_extra: tx_busy high with no frame outstanding");
          else begin
            e_bit = exp_q.pop_front();
            check("txd_bit", 32'(txd_out), 32'(e_bit));
          end
        end else begin
          check("idle_line", 32'(txd_out), 32'd1);
          check("idle_pending", 32'(exp_q.size()), 32'd0);
        end
      end
      check("req", 32'(tx_fifo_rd_data_req),
            32'(tx_fifo_rd_data_valid && clk_en && !tx_busy));
      if (tx_fifo_rd_data_req) begin
        if (fifo_q.size() == 0) fail_now("req with empty fifo");
        else push_frame(fifo_q[0], uart_word_len, uart_parity_en, uart_parity_type, uart_mode);
        pop_pend = 1'b1;
        req_ticks.push_back(tick_no);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int frame_ticks;
    int nreq;
    // Reset with clk_en and valid high: nothing may leak out.
    clk_en = 1'b1;
    tx_fifo_rd_data_valid = 1'b1;
    #12;
    check("rst_txd", 32'(txd_out), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_req", 32'(tx_fifo_rd_data_req), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();

    // 8N1 LSB first, 0x55.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    fifo_q.push_back(8'h55);
    run_until_idle(400);
    // 7E1 MSB first, 0x41.
    set_cfg(2'b10, 1'b1, 1'b0, 1'b1);
    fifo_q.push_back(8'h41);
    run_until_idle(400);
    // 5O1, 0x1F.
    set_cfg(2'b00, 1'b1, 1'b1, 1'b0);
    fifo_q.push_back(8'h1F);
    run_until_idle(400);

    // Three queued bytes back to back: one idle accept tick between frames.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    req_ticks.delete();
    fifo_q.push_back(8'hA3);
    fifo_q.push_back(8'h0F);
    fifo_q.push_back(8'hC6);
    run_until_idle(1000);
    frame_ticks = (1 + 8 + STOP_BITS) * BIT_TICKS;
    check("b2b_req_count", 32'(req_ticks.size()), 32'd3);
    if (req_ticks.size() == 3) begin
      check("b2b_gap0", 32'(req_ticks[1] - req_ticks[0]), 32'(frame_ticks + 1));
      check("b2b_gap1", 32'(req_ticks[2] - req_ticks[1]), 32'(frame_ticks + 1));
    end

    // clk_en 1-in-4, config changed mid-frame.
    en_div = 4;
    en_rand = 1'b0;
    set_cfg(2'b11, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(8'h9B);
    for (int i = 0; i < 60; i++) step();
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
    run_until_idle(2000);

    // Reset during DATA.
    en_div = 1;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    for (int i = 0; i < 20; i++) step();
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd_out), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_req", 32'(tx_fifo_rd_data_req), 32'd0);
    check("midrst_fifo_left", 32'(fifo_q.size()), 32'd1);
    step();
    step();
    check("midrst_hold_txd", 32'(txd_out), 32'd1);
    nreq = req_ticks.size();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_first_tick_req", 32'(req_ticks.size()), 32'(nreq + 1));
    run_until_idle(400);

    // Randomized frames, configs and clk_en density.
    en_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int nb;
      en_div = $urandom_range(1, 4);
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) fifo_q.push_back(8'($urandom));
      for (int i = 0; i < $urandom_range(0, 10); i++) step();
      run_until_idle(4000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
